heater_ramp_ctrl: RTL and testbench
===================================

Name: heater_ramp_ctrl

Overview:
- Upstream controller for the heater array: shift-register toggle fabric and BRAM heaters.
- Generates a PWM gate `heat_en` that qualifies the heater flip-flop toggling, plus `bram_en` for the BRAM heaters.
- Ramps heater duty linearly from 0 to a target and back, so supply current does not step from idle to maximum in one cycle.
- Thermal `alarm` input forces a controlled ramp-down.

Parameters:
- PWM_BITS, 8: width of duty and PWM counter; PWM period = 2^PWM_BITS cycles.
- STEP_CYCLES, 1024: clk cycles per duty step of ±1 during a ramp; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request to begin ramp-up.
- stop  in  1  level-sampled request to ramp down.
- alarm  in  1  thermal alarm; forces ramp-down; blocks start.
- target_duty  in  PWM_BITS  hold duty, sampled on accepted start.
- heat_en  out  1  registered PWM gate to the heater toggle fabric.
- bram_en  out  1  registered; 1 in any state except IDLE.
- duty  out  PWM_BITS  current duty value.
- state  out  2  IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3.
- done  out  1  one-cycle pulse on RAMP_DOWN→IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, duty=0, target_q=0, step_cnt=0, pwm_cnt=0, heat_en=0, bram_en=0, done=0.
- pwm_cnt: free-running, increments every cycle, wraps 2^PWM_BITS−1→0.
- heat_en registered from current duty and pwm_cnt:
  - heat_en = 1 when duty == all-ones (full on).
  - Otherwise heat_en = (pwm_cnt < duty).
  - duty=0 → heat_en constantly 0.
- step_cnt: cleared on every state change; counts 0..STEP_CYCLES−1 while in RAMP_UP/RAMP_DOWN, wraps 0. step strobe = (step_cnt == STEP_CYCLES−1).
- IDLE:
  - Accept start when start=1, stop=0, alarm=0 and target_duty≠0: latch target_q, next state RAMP_UP.
  - Otherwise stay in IDLE. start with target_duty=0 is ignored.
- RAMP_UP:
  - On step strobe: duty += 1.
  - When the incremented duty equals target_q: → HOLD in the same cycle duty is updated.
  - stop=1 or alarm=1 → RAMP_DOWN next cycle, duty unchanged. This wins over a simultaneous step or HOLD transition.
- HOLD:
  - duty = target_q.
  - stop or alarm → RAMP_DOWN.
  - start is ignored; target changes require stop, then a new start.
- RAMP_DOWN:
  - On step strobe: duty −= 1.
  - When the decremented duty equals 0: → IDLE and done=1 for one cycle. done is registered and coincides with the first IDLE cycle.
  - start is ignored until IDLE.
  - Entering RAMP_DOWN with duty=0 → IDLE on the next cycle with done pulse.
- duty never wraps: saturates at 0 and at target_q.
- Latency:
  - start accepted at edge n → state=RAMP_UP visible after edge n.
  - First duty increment after edge n+STEP_CYCLES.
  - Full ramp to target T takes T·STEP_CYCLES cycles; ramp-down from duty D takes D·STEP_CYCLES cycles.
- bram_en = registered (next state ≠ IDLE).
- rst asserted mid-ramp: all outputs return to reset values immediately (async), with no done pulse.
- No combinational input→output paths.

Test Plan (STEP_CYCLES=4, PWM_BITS=8 unless stated):
1. Reset then idle 600 cycles → heat_en=0, bram_en=0, duty=0, state=0 throughout; start with target_duty=0 → state remains 0.
2. start=1 for one cycle, target_duty=3 → state=1 next cycle; duty 1,2,3 at +4,+8,+12 cycles; state=2 at duty=3; in HOLD, heat_en high exactly 3 of every 256 cycles.
3. From HOLD at duty=3, stop=1 → state=3; duty 2,1,0 at 4-cycle intervals; then state=0, done high exactly 1 cycle, bram_en=0.
4. target_duty=255, ramp to HOLD → heat_en=1 every cycle in HOLD; target_duty=128 → heat_en high 128 of 256 cycles, contiguous at pwm_cnt 0..127.
5. alarm=1 during RAMP_UP at duty=5 (target 10) → RAMP_DOWN next cycle, duty 5 then decrementing; start pulses while alarm=1 in IDLE are ignored.
6. rst pulse mid-RAMP_UP at duty=7 → duty=0, heat_en=0, state=0 immediately, done stays 0; start and stop asserted together in IDLE → no transition.

Source files
------------

// File: rtl/heater_ramp_ctrl.sv
// rtl/heater_ramp_ctrl.sv - PWM heater gate with linear duty ramp-up/hold/ramp-down and thermal alarm
module heater_ramp_ctrl #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                alarm,
    input  logic [PWM_BITS-1:0] target_duty,
    output logic                heat_en,
    output logic                bram_en,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          state,
    output logic                done
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_HOLD      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] target_q;
    logic [PWM_BITS-1:0] target_d;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step_strobe;
    logic                done_d;
    logic                ramping;

    assign step_strobe = (step_cnt == STEP_LAST);
    assign ramping     = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DOWN);
    assign state       = state_q;
    assign duty        = duty_q;

    // Next-state, next-duty and target latch; stop/alarm take priority over ramp stepping
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop && !alarm && (target_duty != DUTY_ZERO)) begin
                    target_d = target_duty;
                    state_d  = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (stop || alarm) begin
                    state_d = S_RAMP_DOWN;
                end else if (duty_q >= target_q) begin
                    duty_d  = target_q;
                    state_d = S_HOLD;
                end else if (step_strobe) begin
                    duty_d = duty_q + DUTY_ONE;
                    if ((duty_q + DUTY_ONE) == target_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                duty_d = target_q;
                if (stop || alarm) begin
                    state_d = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (duty_q == DUTY_ZERO) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (step_strobe) begin
                    duty_d = duty_q - DUTY_ONE;
                    if (duty_q == DUTY_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, duty, latched target and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            duty_q   <= DUTY_ZERO;
            target_q <= DUTY_ZERO;
            bram_en  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            bram_en  <= (state_d != S_IDLE);
            done     <= done_d;
        end
    end

    // Ramp step timer: restarts on any state change, runs only while ramping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (state_d != state_q) begin
            step_cnt <= '0;
        end else if (ramping) begin
            step_cnt <= step_strobe ? '0 : step_cnt + STEP_ONE;
        end else begin
            step_cnt <= '0;
        end
    end

    // Free-running PWM counter and registered PWM gate (all-ones duty means always on)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= DUTY_ZERO;
            heat_en <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
            heat_en <= (duty_q == DUTY_FULL) || (pwm_cnt < duty_q);
        end
    end

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// tb/tb_heater_ramp_ctrl.sv - self-checking bench for heater_ramp_ctrl
module tb_heater_ramp_ctrl;

    localparam int STEP   = 4;
    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_HOLD = 2;
    localparam int M_DOWN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       alarm;
    logic [7:0] target_duty;
    logic       heat_en;
    logic       bram_en;
    logic [7:0] duty;
    logic [1:0] state;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode;
    int m_duty;
    int m_target;
    int m_enter;
    int k;
    bit e_heat;
    bit e_bram;
    bit e_done;

    typedef struct {
        int tgt;
        int up_cycles;
        int hold_high;
        int hold_rises;
    } vec_t;

    vec_t vecs[5];

    heater_ramp_ctrl #(
        .PWM_BITS   (8),
        .STEP_CYCLES(STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .alarm      (alarm),
        .target_duty(target_duty),
        .heat_en    (heat_en),
        .bram_en    (bram_en),
        .duty       (duty),
        .state      (state),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_duty   = 0;
        m_target = 0;
        m_enter  = 0;
        k        = 0;
        e_heat   = 1'b0;
        e_bram   = 1'b0;
        e_done   = 1'b0;
    endtask

    // Behavioural model: time since entering a ramp decides steps, global cycle count gives PWM phase
    task automatic model_edge();
        int nm;
        int nd;
        bit strobe;
        bit dn;
        e_heat = (m_duty == 255) || ((k % 256) < m_duty);
        strobe = (k > m_enter) && (((k - m_enter) % STEP) == 0);
        nm = m_mode;
        nd = m_duty;
        dn = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (start && !stop && !alarm && target_duty != 0) begin
                    m_target = target_duty;
                    nm = M_UP;
                end
            end
            M_UP: begin
                if (stop || alarm) nm = M_DOWN;
                else if (strobe) begin
                    nd = m_duty + 1;
                    if (nd == m_target) nm = M_HOLD;
                end
            end
            M_HOLD: begin
                nd = m_target;
                if (stop || alarm) nm = M_DOWN;
            end
            default: begin
                if (m_duty == 0) begin
                    nm = M_IDLE;
                    dn = 1'b1;
                end else if (strobe) begin
                    nd = m_duty - 1;
                    if (nd == 0) begin
                        nm = M_IDLE;
                        dn = 1'b1;
                    end
                end
            end
        endcase
        if (nm != m_mode) m_enter = k;
        m_mode = nm;
        m_duty = nd;
        e_bram = (nm != M_IDLE);
        e_done = dn;
        k++;
    endtask

    task automatic check_cycle();
        n_checks++;
        if (heat_en !== e_heat || bram_en !== e_bram || duty !== 8'(m_duty) ||
            state !== 2'(m_mode) || done !== e_done) begin
            n_fail++;
            $display("FAIL cycle %0d: got heat=%0b bram=%0b duty=%0d state=%0d done=%0b, expected heat=%0b bram=%0b duty=%0d state=%0d done=%0b",
                     k, heat_en, bram_en, duty, state, done, e_heat, e_bram, m_duty, m_mode, e_done);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        int cnt;
        int idle_bad;
        int highs;
        int rises;
        bit prev;

        vecs[0] = '{3,   12,   3,   1};
        vecs[1] = '{1,   4,    1,   1};
        vecs[2] = '{128, 512,  128, 1};
        vecs[3] = '{255, 1020, 256, 0};
        vecs[4] = '{10,  40,   10,  1};

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        alarm = 1'b0;
        target_duty = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", {heat_en, bram_en, duty, state, done}, 0);
        rst = 1'b0;

        // Long idle stays quiet; zero-target start is ignored
        idle_bad = 0;
        repeat (600) begin
            tick();
            if (heat_en || bram_en || duty != 0 || state != 0) idle_bad++;
        end
        check("idle_600_quiet", idle_bad, 0);
        start = 1'b1;
        target_duty = 8'd0;
        tick();
        start = 1'b0;
        check("start_zero_target_state", state, M_IDLE);
        tick();
        check("start_zero_target_bram", bram_en, 0);

        // Table: ramp up, measure PWM in hold, ramp down to done
        for (int v = 0; v < 5; v++) begin
            start = 1'b1;
            target_duty = 8'(vecs[v].tgt);
            tick();
            start = 1'b0;
            check($sformatf("t%0d_enter_ramp_up", vecs[v].tgt), state, M_UP);
            cnt = 0;
            while (state != M_HOLD && cnt < 2000) begin
                tick();
                cnt++;
            end
            check($sformatf("t%0d_ramp_up_cycles", vecs[v].tgt), cnt, vecs[v].up_cycles);
            check($sformatf("t%0d_hold_duty", vecs[v].tgt), duty, vecs[v].tgt);
            tick();
            prev = heat_en;
            highs = 0;
            rises = 0;
            for (int i = 0; i < 256; i++) begin
                tick();
                if (heat_en) highs++;
                if (heat_en && !prev) rises++;
                prev = heat_en;
            end
            check($sformatf("t%0d_hold_heat_high", vecs[v].tgt), highs, vecs[v].hold_high);
            check($sformatf("t%0d_hold_heat_runs", vecs[v].tgt), rises, vecs[v].hold_rises);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check($sformatf("t%0d_enter_ramp_down", vecs[v].tgt), state, M_DOWN);
            cnt = 0;
            while (state != M_IDLE && cnt < 2000) begin
                tick();
                cnt++;
            end
            check($sformatf("t%0d_ramp_down_cycles", vecs[v].tgt), cnt, vecs[v].up_cycles);
            check($sformatf("t%0d_done_pulse", vecs[v].tgt), done, 1);
            check($sformatf("t%0d_bram_off", vecs[v].tgt), bram_en, 0);
            tick();
            check($sformatf("t%0d_done_single", vecs[v].tgt), done, 0);
        end

        // Alarm mid ramp-up at duty 5, then start blocked by alarm in idle
        start = 1'b1;
        target_duty = 8'd10;
        tick();
        start = 1'b0;
        cnt = 0;
        while (duty != 5 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("alarm_reach_duty5", duty, 5);
        alarm = 1'b1;
        tick();
        check("alarm_state_down", state, M_DOWN);
        check("alarm_duty_held", duty, 5);
        cnt = 0;
        while (state != M_IDLE && cnt < 200) begin
            tick();
            cnt++;
        end
        check("alarm_ramp_down_cycles", cnt, 5 * STEP);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            target_duty = 8'd5;
            tick();
            start = 1'b0;
            check("alarm_blocks_start", state, M_IDLE);
            tick();
        end
        alarm = 1'b0;

        // Async reset mid ramp-up at duty 7
        start = 1'b1;
        target_duty = 8'd10;
        tick();
        start = 1'b0;
        cnt = 0;
        while (duty != 7 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("rst_reach_duty7", duty, 7);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {heat_en, bram_en, duty, state, done}, 0);
        model_reset();
        @(negedge clk);
        check("rst_no_done", done, 0);
        rst = 1'b0;
        start = 1'b1;
        stop = 1'b1;
        target_duty = 8'd5;
        tick();
        check("start_stop_together", state, M_IDLE);
        start = 1'b0;
        stop = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000 && n_fail < 50; i++) begin
            start = ($urandom % 4) == 0;
            stop = ($urandom % 40) == 0;
            alarm = ($urandom % 60) == 0;
            target_duty = (($urandom % 8) == 0) ? 8'd255 : 8'($urandom % 7);
            if (($urandom % 500) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_cycle();
                @(negedge clk);
                rst = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
